mio_bus_arbiter: RTL and testbench

Memory/IO bus controller between the single-cycle CPU's data port and the shared data memory/peripheral bus. It arbitrates that bus between the CPU and a debug/DMA requester and runs a req/ack handshake with variable-latency slaves. It stalls the CPU through `MIO_ready` until its access completes. A watchdog aborts transfers that are never acknowledged.

---
 rtl/mio_bus_arbiter_if.sv | 37 +++
 rtl/mio_bus_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mio_bus_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mio_bus_arbiter_if.sv
// Shared data-memory / peripheral bus. The arbiter is the master; memory and
// peripheral slaves sit on the slave side and answer with a variable-latency ack.
interface mio_bus_arbiter_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [2:0]  bus_dmtype;
  logic        bus_sel_io;
  logic        bus_err;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    output bus_dmtype,
    output bus_sel_io,
    output bus_err,
    input  bus_rdata,
    input  bus_ack
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    input  bus_dmtype,
    input  bus_sel_io,
    input  bus_err,
    output bus_rdata,
    output bus_ack
  );
endinterface

// File: rtl/mio_bus_arbiter.sv
// Memory/IO bus controller: round-robin arbitration between the CPU data port and
// a debug/DMA requester, req/ack handshake with variable-latency slaves, watchdog abort.
module mio_bus_arbiter #(
  parameter logic [3:0]  IO_BASE_NIB = 4'hF,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  input  logic [2:0]        cpu_dmtype_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_ready_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [31:0]       dbg_addr_i,
  input  logic [31:0]       dbg_wdata_i,
  output logic [31:0]       dbg_rdata_o,
  output logic              dbg_ack_o,
  mio_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [2:0] DMT_WORD  = 3'b010;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q,      state_d;
  logic        last_dbg_q,   last_dbg_d;
  logic        gnt_dbg_q,    gnt_dbg_d;
  logic [7:0]  wait_cnt_q,   wait_cnt_d;
  logic        bus_req_q,    bus_req_d;
  logic        bus_we_q,     bus_we_d;
  logic [31:0] bus_addr_q,   bus_addr_d;
  logic [31:0] bus_wdata_q,  bus_wdata_d;
  logic [2:0]  bus_dmtype_q, bus_dmtype_d;
  logic        bus_sel_io_q, bus_sel_io_d;
  logic [31:0] cpu_rdata_q,  cpu_rdata_d;
  logic [31:0] dbg_rdata_q,  dbg_rdata_d;
  logic        cpu_done_q,   cpu_done_d;
  logic        dbg_done_q,   dbg_done_d;

  logic        pick_dbg_s;
  logic        ack_s;
  logic        timeout_s;
  logic [31:0] rd_load_s;

  // On a tie the requester that was not served last wins.
  assign pick_dbg_s = dbg_req_i & (~cpu_req_i | ~last_dbg_q);
  assign ack_s      = (state_q == ST_XFER) & bus.bus_ack;
  assign timeout_s  = (state_q == ST_XFER) & ~bus.bus_ack & (wait_cnt_q == WAIT_LAST);
  assign rd_load_s  = ack_s ? bus.bus_rdata : 32'h0000_0000;

  // Next-state and next-output computation for the transfer FSM.
  always_comb begin
    state_d      = state_q;
    last_dbg_d   = last_dbg_q;
    gnt_dbg_d    = gnt_dbg_q;
    wait_cnt_d   = wait_cnt_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_dmtype_d = bus_dmtype_q;
    bus_sel_io_d = bus_sel_io_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    cpu_done_d   = 1'b0;
    dbg_done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req_i || dbg_req_i) begin
          if (pick_dbg_s) begin
            bus_we_d     = dbg_we_i;
            bus_addr_d   = dbg_addr_i;
            bus_wdata_d  = dbg_wdata_i;
            bus_dmtype_d = DMT_WORD;
            bus_sel_io_d = (dbg_addr_i[31:28] == IO_BASE_NIB);
            gnt_dbg_d    = 1'b1;
            last_dbg_d   = 1'b1;
          end else begin
            bus_we_d     = cpu_we_i;
            bus_addr_d   = cpu_addr_i;
            bus_wdata_d  = cpu_wdata_i;
            bus_dmtype_d = cpu_dmtype_i;
            bus_sel_io_d = (cpu_addr_i[31:28] == IO_BASE_NIB);
            gnt_dbg_d    = 1'b0;
            last_dbg_d   = 1'b0;
          end
          bus_req_d  = 1'b1;
          wait_cnt_d = 8'd0;
          state_d    = ST_XFER;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_XFER: begin
        // An ack in the final wait cycle beats the watchdog.
        if (ack_s || timeout_s) begin
          if (!bus_we_q) begin
            if (gnt_dbg_q) begin
              dbg_rdata_d = rd_load_s;
            end else begin
              cpu_rdata_d = rd_load_s;
            end
          end else begin
            cpu_rdata_d = cpu_rdata_q;
            dbg_rdata_d = dbg_rdata_q;
          end
          cpu_done_d = ~gnt_dbg_q;
          dbg_done_d = gnt_dbg_q;
          bus_req_d  = 1'b0;
          state_d    = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      ST_RESP: begin
        bus_req_d = 1'b0;
        state_d   = ST_IDLE;
      end

      default: begin
        bus_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset leaves the CPU winning the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      last_dbg_q   <= 1'b1;
      gnt_dbg_q    <= 1'b0;
      wait_cnt_q   <= 8'd0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'h0000_0000;
      bus_wdata_q  <= 32'h0000_0000;
      bus_dmtype_q <= 3'b000;
      bus_sel_io_q <= 1'b0;
      cpu_rdata_q  <= 32'h0000_0000;
      dbg_rdata_q  <= 32'h0000_0000;
      cpu_done_q   <= 1'b0;
      dbg_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_dbg_q   <= last_dbg_d;
      gnt_dbg_q    <= gnt_dbg_d;
      wait_cnt_q   <= wait_cnt_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_dmtype_q <= bus_dmtype_d;
      bus_sel_io_q <= bus_sel_io_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      cpu_done_q   <= cpu_done_d;
      dbg_done_q   <= dbg_done_d;
    end
  end

  assign bus.bus_req    = bus_req_q;
  assign bus.bus_we     = bus_we_q;
  assign bus.bus_addr   = bus_addr_q;
  assign bus.bus_wdata  = bus_wdata_q;
  assign bus.bus_dmtype = bus_dmtype_q;
  assign bus.bus_sel_io = bus_sel_io_q;
  // The abort pulse lands in the last wait cycle so done can follow one cycle later.
  assign bus.bus_err    = timeout_s;

  assign cpu_rdata_o = cpu_rdata_q;
  assign dbg_rdata_o = dbg_rdata_q;
  // A CPU without a memory access pending is never stalled.
  assign cpu_ready_o = ~cpu_req_i | cpu_done_q;
  assign dbg_ack_o   = dbg_done_q;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Randomized bench for mio_bus_arbiter against a transaction-level timing model:
// each grant is reduced to start cycle, done cycle, error cycle and result data.
module tb_mio_bus_arbiter;
  localparam int TMO   = 16;
  localparam int NEVER = 1000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0;
  logic [31:0] cpu_addr_i = 32'h0, cpu_wdata_i = 32'h0;
  logic [2:0]  cpu_dmtype_i = 3'b000;
  logic [31:0] cpu_rdata_o;
  logic        cpu_ready_o;
  logic        dbg_req_i = 1'b0, dbg_we_i = 1'b0;
  logic [31:0] dbg_addr_i = 32'h0, dbg_wdata_i = 32'h0;
  logic [31:0] dbg_rdata_o;
  logic        dbg_ack_o;

  mio_bus_arbiter_if bus_if ();

  mio_bus_arbiter #(.IO_BASE_NIB(4'hF), .TIMEOUT(TMO)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cpu_req_i    (cpu_req_i),
    .cpu_we_i     (cpu_we_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_dmtype_i (cpu_dmtype_i),
    .cpu_rdata_o  (cpu_rdata_o),
    .cpu_ready_o  (cpu_ready_o),
    .dbg_req_i    (dbg_req_i),
    .dbg_we_i     (dbg_we_i),
    .dbg_addr_i   (dbg_addr_i),
    .dbg_wdata_i  (dbg_wdata_i),
    .dbg_rdata_o  (dbg_rdata_o),
    .dbg_ack_o    (dbg_ack_o),
    .bus          (bus_if.master)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Requester agents: a pending transaction is held until its done cycle.
  bit          cpu_pend = 1'b0, dbg_pend = 1'b0;
  logic        a_cpu_we, a_dbg_we;
  logic [31:0] a_cpu_addr, a_cpu_wdata, a_dbg_addr, a_dbg_wdata;
  logic [2:0]  a_cpu_dmt;
  bit          rand_on = 1'b0, auto_on = 1'b0;
  int          lat_force = 0;
  bit          data_force_en = 1'b0;
  logic [31:0] data_force = 32'h0;

  // Transaction-level model of the bus.
  bit          busy = 1'b0, own_dbg = 1'b0, tmo = 1'b0, last_dbg = 1'b1;
  int          c0 = 0, d0 = 0, lat = 0;
  logic        x_we;
  logic [31:0] x_addr, x_wdata, ack_data;
  logic [2:0]  x_dmt;
  logic [31:0] m_cpu_rdata = 32'h0, m_dbg_rdata = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom();
    if ($urandom_range(0, 1) == 1) a[31:28] = 4'hF;
    return a;
  endfunction

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0, 1, 2, 3: return r;
      4, 5:       return $urandom_range(4, 14);
      6:          return TMO - 1;
      7:          return NEVER;
      8:          return TMO - 2;
      default:    return 0;
    endcase
  endfunction

  task automatic cpu_issue(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] dmt);
    cpu_pend = 1'b1; a_cpu_we = we; a_cpu_addr = addr; a_cpu_wdata = wd; a_cpu_dmt = dmt;
  endtask

  task automatic dbg_issue(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    dbg_pend = 1'b1; a_dbg_we = we; a_dbg_addr = addr; a_dbg_wdata = wd;
  endtask

  task automatic drive_inputs();
    if (!cpu_pend && (rand_on ? ($urandom_range(0, 2) == 0) : auto_on))
      cpu_issue(1'($urandom_range(0, 1)), rand_addr(), $urandom(), 3'($urandom_range(0, 7)));
    if (!dbg_pend && (rand_on ? ($urandom_range(0, 2) == 0) : auto_on))
      dbg_issue(1'($urandom_range(0, 1)), rand_addr(), $urandom());
    cpu_req_i    = cpu_pend;
    cpu_we_i     = cpu_pend ? a_cpu_we : 1'($urandom_range(0, 1));
    cpu_addr_i   = cpu_pend ? a_cpu_addr : $urandom();
    cpu_wdata_i  = cpu_pend ? a_cpu_wdata : $urandom();
    cpu_dmtype_i = cpu_pend ? a_cpu_dmt : 3'($urandom_range(0, 7));
    dbg_req_i    = dbg_pend;
    dbg_we_i     = dbg_pend ? a_dbg_we : 1'($urandom_range(0, 1));
    dbg_addr_i   = dbg_pend ? a_dbg_addr : $urandom();
    dbg_wdata_i  = dbg_pend ? a_dbg_wdata : $urandom();
    // Slave: ack only at the scripted cycle during a transfer, random noise elsewhere.
    if (busy && cyc > c0 && cyc < d0) begin
      bus_if.bus_ack   = (!tmo && cyc == c0 + 1 + lat);
      bus_if.bus_rdata = bus_if.bus_ack ? ack_data : $urandom();
    end else begin
      bus_if.bus_ack   = ($urandom_range(0, 3) == 0);
      bus_if.bus_rdata = $urandom();
    end
  endtask

  task automatic check_outputs();
    bit xfer, done;
    xfer = busy && cyc > c0 && cyc < d0;
    done = busy && cyc == d0;
    check_eq("bus_req", 32'(bus_if.bus_req), 32'(xfer));
    check_eq("bus_err", 32'(bus_if.bus_err), 32'(busy && tmo && cyc == d0 - 1));
    check_eq("cpu_ready", 32'(cpu_ready_o), 32'(!cpu_pend || (done && !own_dbg)));
    check_eq("dbg_ack", 32'(dbg_ack_o), 32'(done && own_dbg));
    check_eq("cpu_rdata", cpu_rdata_o, m_cpu_rdata);
    check_eq("dbg_rdata", dbg_rdata_o, m_dbg_rdata);
    if (xfer) begin
      check_eq("bus_we", 32'(bus_if.bus_we), 32'(x_we));
      check_eq("bus_addr", bus_if.bus_addr, x_addr);
      check_eq("bus_wdata", bus_if.bus_wdata, x_wdata);
      check_eq("bus_dmtype", 32'(bus_if.bus_dmtype), 32'(x_dmt));
      check_eq("bus_sel_io", 32'(bus_if.bus_sel_io), 32'(x_addr[31:28] == 4'hF));
    end
  endtask

  task automatic model_update();
    if (busy) begin
      if (cyc == d0 - 1 && !x_we) begin
        if (own_dbg) m_dbg_rdata = tmo ? 32'h0 : ack_data;
        else         m_cpu_rdata = tmo ? 32'h0 : ack_data;
      end
      if (cyc == d0) begin
        busy = 1'b0;
        if (own_dbg) dbg_pend = 1'b0;
        else         cpu_pend = 1'b0;
      end
    end else if (cpu_pend || dbg_pend) begin
      own_dbg  = dbg_pend && (!cpu_pend || !last_dbg);
      last_dbg = own_dbg;
      x_we     = own_dbg ? a_dbg_we : a_cpu_we;
      x_addr   = own_dbg ? a_dbg_addr : a_cpu_addr;
      x_wdata  = own_dbg ? a_dbg_wdata : a_cpu_wdata;
      x_dmt    = own_dbg ? 3'b010 : a_cpu_dmt;
      lat      = (lat_force >= 0) ? lat_force : pick_lat();
      ack_data = data_force_en ? data_force : $urandom();
      c0       = cyc;
      if (lat <= TMO - 1) begin tmo = 1'b0; d0 = c0 + 2 + lat; end
      else                begin tmo = 1'b1; d0 = c0 + TMO + 1; end
      busy = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk_i); #1; cyc++;
    drive_inputs();
    @(negedge clk_i);
    check_outputs();
    model_update();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_vals();
    check_eq("rst_bus_we", 32'(bus_if.bus_we), 32'd0);
    check_eq("rst_bus_addr", bus_if.bus_addr, 32'h0);
    check_eq("rst_bus_wdata", bus_if.bus_wdata, 32'h0);
    check_eq("rst_bus_dmtype", 32'(bus_if.bus_dmtype), 32'd0);
    check_eq("rst_bus_sel_io", 32'(bus_if.bus_sel_io), 32'd0);
  endtask

  // Asserts reset mid-cycle (async), holds it two cycles, releases before an edge.
  task automatic do_reset();
    @(posedge clk_i); #1; cyc++;
    drive_inputs();
    #2; rst_ni = 1'b0; #1;
    check_eq("rst_async_bus_req", 32'(bus_if.bus_req), 32'd0);
    busy = 1'b0; last_dbg = 1'b1; m_cpu_rdata = 32'h0; m_dbg_rdata = 32'h0;
    @(negedge clk_i);
    check_outputs();
    check_reset_vals();
    @(posedge clk_i); #1; cyc++;
    drive_inputs();
    @(negedge clk_i);
    check_outputs();
    check_reset_vals();
    #2; rst_ni = 1'b1;
    model_update();
  endtask

  initial begin
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h0;
    // CPU read from data memory, single-cycle slave, known data.
    cpu_issue(1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 3'b010);
    lat_force = 0; data_force_en = 1'b1; data_force = 32'h1234_5678;
    do_reset();
    run_cycles(5);
    check_eq("cpu_read_data", cpu_rdata_o, 32'h1234_5678);
    data_force_en = 1'b0;

    // CPU byte write to IO space with three wait cycles.
    cpu_issue(1'b1, 32'hF000_0004, 32'h0000_00A5, 3'b000);
    lat_force = 3;
    run_cycles(9);
    check_eq("cpu_write_keeps_rdata", cpu_rdata_o, 32'h1234_5678);

    // Continuous contention from reset: CPU must win first, then alternate.
    cpu_issue(1'b0, rand_addr(), $urandom(), 3'b010);
    dbg_issue(1'b0, rand_addr(), $urandom());
    lat_force = 0; auto_on = 1'b1;
    do_reset();
    run_cycles(13);
    auto_on = 1'b0;
    run_cycles(8);

    // Debug read never acknowledged: watchdog abort, zero data.
    dbg_issue(1'b0, 32'h0000_0100, 32'h0);
    lat_force = NEVER;
    run_cycles(22);
    check_eq("timeout_dbg_rdata", dbg_rdata_o, 32'h0);

    // Ack in the very last wait cycle: data captured, no error.
    cpu_issue(1'b0, 32'hF000_0020, 32'h0, 3'b010);
    lat_force = TMO - 1; data_force_en = 1'b1; data_force = 32'hCAFE_F00D;
    run_cycles(22);
    check_eq("collision_cpu_rdata", cpu_rdata_o, 32'hCAFE_F00D);
    data_force_en = 1'b0;

    // Randomized traffic from both requesters with random slave latency.
    lat_force = -1; rand_on = 1'b1;
    run_cycles(3000);
    rand_on = 1'b0;
    run_cycles(50);

    // Reset during a CPU write's wait; the held request restarts afterwards.
    cpu_issue(1'b1, 32'h0000_0040, 32'h5555_AAAA, 3'b001);
    lat_force = NEVER;
    run_cycles(6);
    lat_force = 2;
    do_reset();
    run_cycles(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
